uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
16x-oversampling UART receiver. It is the robust receive-side counterpart to the team's uarttx serializer.
- Recovers 8N1 frames (optionally 8E1) from an asynchronous rx line.
- Samples each bit at its centre and rejects glitch start bits.
- Flags framing, parity and overrun errors.
- Presents bytes on a valid/ready holding register for a downstream FIFO or CPU bridge.

Parameters:
CLK_FREQ, 1000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate in bit/s
OVERSAMPLE, 16, sample ticks per bit; must be even and >= 4

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
rx_data  output  8  received byte, valid while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts byte when rx_valid&rx_ready at posedge clk
frame_err  output  1  one-cycle pulse: stop bit sampled 0
parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without PARITY_EN)
overrun  output  1  one-cycle pulse: byte completed while holding register full
busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: clock clk; reset rst, synchronous, active-high.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, state=IDLE, synchronizer flops=1, all counters=0.
- Tick generator: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division, clamped to a minimum of 1. The counter runs 0..DIV-1 and emits a one-clk tick at DIV-1. It is free-running and reset only by rst.
- rx passes through a 2-flop synchronizer (rx_s) before any use.
- State machine, evaluated on ticks only:
  - IDLE: when rx_s=0, go to START and clear the tick counter.
  - START: count OVERSAMPLE/2 ticks, then sample rx_s.
    - rx_s=1: false start, return to IDLE.
    - rx_s=0: go to DATA with bit index 0.
  - DATA: every OVERSAMPLE ticks, sample rx_s into bit[index], LSB first.
    - After index 7, go to PARITY if PARITY_EN is defined, otherwise STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - 1: deliver the byte and go to IDLE.
    - 0: frame_err pulse, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This blocks retriggering during a break.
- Delivery, in the clk cycle after the stop-sample tick:
  - If rx_valid=0, or rx_ready=1 in that same cycle: load rx_data and set rx_valid=1.
  - Otherwise: pulse overrun, drop the new byte, keep the old rx_data.
- Handshake:
  - rx_valid clears on the accepting cycle unless a new byte loads in that same cycle; in that case rx_valid stays 1 with the new data.
  - rx_data must be stable while rx_valid=1.
- Error pulses are exactly one clk wide.
- Reset mid-frame returns to IDLE on the next clk. A partial byte is never delivered.
- Latency: rx_valid rises 1 clk after the centre-of-stop tick, i.e. about 9.5 bit periods after the start edge, plus the 2-clk synchronizer delay.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: a PARITY state is inserted between DATA and STOP. It samples one bit after OVERSAMPLE ticks and checks even parity (XOR of 8 data bits and the parity bit must be 0).
  - Mismatch: parity_err pulses when STOP is evaluated and the byte is discarded.
  - Stop-bit checking is unchanged.
  - If both parity and stop bit are bad, both error pulses fire in the same cycle.
- Not defined: no PARITY state, parity_err tied 0, frame is 8N1.

Test Plan:
Defaults give DIV=6 and a bit period of 96 clk.
- Send 0xA5 as 8N1 with rx_ready=1 -> rx_valid for 1 clk with rx_data=0xA5, no error pulses, busy low afterwards.
- Low glitch of 40 clk (shorter than a half bit) on idle line -> returns to IDLE, no rx_valid, no frame_err. Then send 0x3C -> received correctly.
- Send 0x5A with stop bit forced 0, line held low for 300 clk then high -> one frame_err pulse, no rx_valid, waits in WAIT_HIGH. Next frame 0x01 -> received correctly.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, one overrun pulse. Assert rx_ready -> rx_valid drops.
- Reset asserted at data bit 4 of 0xFF -> all outputs reset, no delivery. Send 0x80 -> received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity 1 -> rx_data=0x07. Send 0x07 with parity 0 -> parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_rx_os_if.sv
// Receive-side byte handshake of uart_rx_os: valid/ready holding register plus status pulses.
// master = receiver, slave = downstream consumer.
interface uart_rx_os_if;
  // A byte transfers on any posedge clk where rx_valid && rx_ready. rx_data is held stable while
  // rx_valid=1. rx_valid drops after acceptance unless a new byte is loaded in the same cycle.
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with
// centre sampling, false-start rejection, error pulses and a valid/ready holding register.
module uart_rx_os #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_rx_os_if.master   bus,
    output logic [2:0]     fsm_state
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W    = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_M1  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  HALF_M1 = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  FULL_M1 = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t           state, state_n;
    logic             rx_m, rx_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [OS_W-1:0]  os_cnt, os_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       data_sr, data_sr_n;
    logic             stop_good, stop_bad;
    logic             deliver_q;
`ifdef UART_RX_PARITY_EN
    logic             par_bit, par_bit_n;
    logic             par_bad;
`endif

    assign tick      = (div_cnt == DIV_M1);
    assign bus.busy  = (state != IDLE);
    assign fsm_state = state;

    always_comb begin
        state_n   = state;
        os_cnt_n  = os_cnt;
        bit_idx_n = bit_idx;
        data_sr_n = data_sr;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n = par_bit;
        par_bad   = 1'b0;
`endif
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n  = START;
                        os_cnt_n = '0;
                    end
                end
                START: begin
                    // Half a bit after the falling edge: a high line here was only a glitch.
                    if (os_cnt == HALF_M1) begin
                        os_cnt_n  = '0;
                        bit_idx_n = '0;
                        state_n   = rx_s ? IDLE : DATA;
                    end else begin
                        os_cnt_n = os_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (os_cnt == FULL_M1) begin
                        os_cnt_n  = '0;
                        data_sr_n = {rx_s, data_sr[7:1]};
                        bit_idx_n = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end
                    end else begin
                        os_cnt_n = os_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (os_cnt == FULL_M1) begin
                        os_cnt_n  = '0;
                        par_bit_n = rx_s;
                        state_n   = STOP;
                    end else begin
                        os_cnt_n = os_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (os_cnt == FULL_M1) begin
                        os_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad  = ^{data_sr, par_bit};
`endif
                        if (rx_s) begin
                            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                            stop_good = !par_bad;
`else
                            stop_good = 1'b1;
`endif
                        end else begin
                            stop_bad = 1'b1;
                            state_n  = WAIT_HIGH;
                        end
                    end else begin
                        os_cnt_n = os_cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m           <= 1'b1;
            rx_s           <= 1'b1;
            div_cnt        <= '0;
            state          <= IDLE;
            os_cnt         <= '0;
            bit_idx        <= '0;
            data_sr        <= '0;
            deliver_q      <= 1'b0;
            bus.rx_data    <= '0;
            bus.rx_valid   <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit        <= 1'b0;
`endif
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;
            state     <= state_n;
            os_cnt    <= os_cnt_n;
            bit_idx   <= bit_idx_n;
            data_sr   <= data_sr_n;
            deliver_q <= stop_good;
            bus.frame_err <= stop_bad;
`ifdef UART_RX_PARITY_EN
            par_bit        <= par_bit_n;
            bus.parity_err <= par_bad;
`else
            bus.parity_err <= 1'b0;
`endif
            // A full, unread holding register keeps its byte; the new one is dropped.
            bus.overrun <= deliver_q && bus.rx_valid && !bus.rx_ready;
            if (deliver_q && (!bus.rx_valid || bus.rx_ready)) begin
                bus.rx_data  <= data_sr;
                bus.rx_valid <= 1'b1;
            end else if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end
        end
    end

endmodule
